cmp_mmio_router: RTL and testbench

- Next-generation memory-mapped request router between the cardinal CMP core's EX/MEM memory port and NUM_TGT slave targets (data memory, NIC, future peripherals).
- Decodes a parametrised address field and forwards each request to exactly one target with a ready/valid handshake.
- Registers load data and stalls the core until the access completes.
- Replaces the fixed two-way dmem/NIC combinational steer. Variable-latency targets and decode errors are now handled.

---
 rtl/cmp_mmio_router_pkg.sv | 18 +
 rtl/cmp_mmio_router_if.sv | 32 +++
 rtl/cmp_mmio_router_decode.sv | 17 +
 rtl/cmp_mmio_router.sv | 144 ++++++++++++++
 tb/tb_cmp_mmio_router.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cmp_mmio_router_pkg.sv
// Shared constants for the CMP memory-mapped router: FSM encoding, well-known
// target indices and the default placement of the target-select address field.
package cardinal_mmio_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int TGT_DMEM = 0;
  localparam int TGT_NIC  = 3;

  localparam int DEF_SEL_MSB = 16;
  localparam int DEF_SEL_W   = 2;

endpackage

// File: rtl/cmp_mmio_router_if.sv
// Core/target bus bundle for cmp_mmio_router. All vectors are ascending: bit 0 is the MSB.
// master = core plus target environment, slave = the router itself.
interface cmp_mmio_router_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int NUM_TGT = 4
);
  logic                        cpu_en;
  logic                        cpu_wr_en;
  logic [0:ADDR_W-1]           cpu_addr;
  logic [0:DATA_W-1]           cpu_wdata;
  logic [0:DATA_W-1]           cpu_rdata;
  logic                        cpu_stall;
  logic [0:NUM_TGT-1]          tgt_en;
  logic [0:NUM_TGT-1]          tgt_wr_en;
  logic [0:ADDR_W-1]           tgt_addr;
  logic [0:DATA_W-1]           tgt_wdata;
  logic [0:NUM_TGT-1]          tgt_ready;
  logic [0:NUM_TGT-1]          tgt_rvalid;
  logic [0:NUM_TGT*DATA_W-1]   tgt_rdata;
  logic                        bus_err;

  modport master (
    output cpu_en, cpu_wr_en, cpu_addr, cpu_wdata, tgt_ready, tgt_rvalid, tgt_rdata,
    input  cpu_rdata, cpu_stall, tgt_en, tgt_wr_en, tgt_addr, tgt_wdata, bus_err
  );

  modport slave (
    input  cpu_en, cpu_wr_en, cpu_addr, cpu_wdata, tgt_ready, tgt_rvalid, tgt_rdata,
    output cpu_rdata, cpu_stall, tgt_en, tgt_wr_en, tgt_addr, tgt_wdata, bus_err
  );
endinterface

// File: rtl/cmp_mmio_router_decode.sv
// Combinational address decode: extracts the target-select field (SEL_MSB is its
// most significant bit in the ascending address) and flags indices >= NUM_TGT.
module cmp_mmio_decode #(
  parameter int ADDR_W  = 32,
  parameter int SEL_MSB = 16,
  parameter int SEL_W   = 2,
  parameter int NUM_TGT = 4
) (
  input  logic [0:ADDR_W-1] addr_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              valid_o
);

  assign idx_o   = addr_i[SEL_MSB +: SEL_W];
  assign valid_o = (int'(idx_o) < NUM_TGT);

endmodule

// File: rtl/cmp_mmio_router.sv
// Memory-mapped request router from the CMP EX/MEM port to NUM_TGT ready/valid targets.
// Optional handshake timeout is compiled in with `define CMP_MMIO_TIMEOUT_EN.
module cmp_mmio_router
  import cardinal_mmio_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int NUM_TGT     = 4,
  parameter int SEL_MSB     = DEF_SEL_MSB,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  cmp_mmio_router_if.slave   bus
);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [0:ADDR_W-1]  addr_q, addr_d;
  logic [0:DATA_W-1]  wdata_q, wdata_d;
  logic [0:DATA_W-1]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [SEL_W-1:0]   dec_idx;
  logic               dec_vld;
  logic               tmo;

  cmp_mmio_decode #(
    .ADDR_W  (ADDR_W),
    .SEL_MSB (SEL_MSB),
    .SEL_W   (SEL_W),
    .NUM_TGT (NUM_TGT)
  ) u_decode (
    .addr_i  (bus.cpu_addr),
    .idx_o   (dec_idx),
    .valid_o (dec_vld)
  );

`ifdef CMP_MMIO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counter is zero on the first REQ cycle, so tmo fires in the TIMEOUT_CYC-th waiting cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == ST_REQ || state_q == ST_RSP) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_en) begin
          idx_d   = dec_idx;
          wr_d    = bus.cpu_wr_en;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          if (dec_vld) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            if (!bus.cpu_wr_en) rdata_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (bus.tgt_ready[idx_q]) begin
          state_d = wr_q ? ST_DONE : ST_RSP;
        end else if (tmo) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (!wr_q) rdata_d = '0;
        end
      end
      ST_RSP: begin
        if (bus.tgt_rvalid[idx_q]) begin
          rdata_d = bus.tgt_rdata[DATA_W*int'(idx_q) +: DATA_W];
          state_d = ST_DONE;
        end else if (tmo) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    bus.tgt_en    = '0;
    bus.tgt_wr_en = '0;
    if (state_q == ST_REQ) begin
      bus.tgt_en[idx_q]    = 1'b1;
      bus.tgt_wr_en[idx_q] = wr_q;
    end
  end

  assign bus.tgt_addr  = addr_q;
  assign bus.tgt_wdata = wdata_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.bus_err   = err_q;
  assign bus.cpu_stall = bus.cpu_en && (state_q != ST_DONE);

endmodule

// File: tb/tb_cmp_mmio_router.sv
// Directed bench for cmp_mmio_router: stores, loads, decode error, async reset,
// back-to-back loads and (with CMP_MMIO_TIMEOUT_EN) the handshake timeout.
module tb_cmp_mmio_router;
  import cardinal_mmio_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cmp_mmio_router_if #(.ADDR_W(32), .DATA_W(64), .NUM_TGT(4)) bus ();
  cmp_mmio_router_if #(.ADDR_W(32), .DATA_W(64), .NUM_TGT(3)) bus3 ();

  cmp_mmio_router #(.ADDR_W(32), .DATA_W(64), .NUM_TGT(4), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cmp_mmio_router #(.ADDR_W(32), .DATA_W(64), .NUM_TGT(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int ns     = 0;

  localparam logic [63:0] D_NIC = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_A   = 64'hA5A5_0000_1111_2222;
  localparam logic [63:0] D_B   = 64'h3C3C_4444_5555_6666;
  localparam logic [63:0] D_T1  = 64'h5555_AAAA_0F0F_F0F0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_en = 1'b0;  bus.cpu_wr_en = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.tgt_ready = '0; bus.tgt_rvalid = '0;   bus.tgt_rdata = '0;
    bus3.cpu_en = 1'b0; bus3.cpu_wr_en = 1'b0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    bus3.tgt_ready = 3'b111; bus3.tgt_rvalid = 3'b111; bus3.tgt_rdata = '0;
    bus3.tgt_rdata[64 +: 64] = D_T1;

    // Reset state
    tick(); tick();
    chk("rst_tgt_en", 64'(bus.tgt_en), 64'h0);
    chk("rst_bus_err", 64'(bus.bus_err), 64'h0);
    chk("rst_rdata", bus.cpu_rdata, 64'h0);
    chk("rst_tgt_addr", 64'(bus.tgt_addr), 64'h0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset = 1'b0;

    // Store to dmem, ready tied high
    bus.cpu_en = 1'b1; bus.cpu_wr_en = 1'b1; bus.cpu_addr = 32'h0000_0010;
    bus.cpu_wdata = 64'hDEAD_BEEF_0000_0001; bus.tgt_ready = 4'b1000;
    ns = 0;
    #1; ns += int'(bus.cpu_stall);
    chk("st_idle_stall", 64'(bus.cpu_stall), 64'h1);
    chk("st_idle_en", 64'(bus.tgt_en), 64'h0);
    tick(); ns += int'(bus.cpu_stall);
    chk("st_req_en", 64'(bus.tgt_en), 64'b1000);
    chk("st_req_wr", 64'(bus.tgt_wr_en), 64'b1000);
    chk("st_req_addr", 64'(bus.tgt_addr), 64'h10);
    chk("st_req_wdata", bus.tgt_wdata, 64'hDEAD_BEEF_0000_0001);
    tick(); ns += int'(bus.cpu_stall);
    chk("st_done_stall", 64'(bus.cpu_stall), 64'h0);
    chk("st_done_en", 64'(bus.tgt_en), 64'h0);
    chk("st_done_err", 64'(bus.bus_err), 64'h0);
    tick();
    bus.cpu_en = 1'b0; bus.tgt_ready = '0;
    chk("st_stall_cycles", 64'(ns), 64'd2);

    // Load from NIC: ready low 3 cycles, rvalid in the second RSP cycle
    bus.cpu_en = 1'b1; bus.cpu_wr_en = 1'b0; bus.cpu_addr = 32'h0000_C000;
    bus.tgt_rdata[192 +: 64] = 64'hBAD0_BAD0_BAD0_BAD0;
    ns = 0;
    #1; ns += int'(bus.cpu_stall);
    repeat (3) begin tick(); ns += int'(bus.cpu_stall); end
    chk("ld_req_en", 64'(bus.tgt_en), 64'b0001);
    chk("ld_req_wr", 64'(bus.tgt_wr_en), 64'h0);
    tick();
    bus.tgt_ready = 4'b0001; bus.tgt_rvalid = 4'b0001;
    #1; ns += int'(bus.cpu_stall);
    tick();
    bus.tgt_ready = '0; bus.tgt_rvalid = '0; bus.tgt_rdata[192 +: 64] = D_NIC;
    #1; ns += int'(bus.cpu_stall);
    chk("ld_rsp_en", 64'(bus.tgt_en), 64'h0);
    chk("ld_rvalid_with_ready_ignored", bus.cpu_rdata, 64'h0);
    chk("ld_rsp_state", 64'(dut.state_q), 64'(ST_RSP));
    tick();
    bus.tgt_rvalid = 4'b0001;
    #1; ns += int'(bus.cpu_stall);
    tick();
    bus.tgt_rvalid = '0;
    ns += int'(bus.cpu_stall);
    chk("ld_done_rdata", bus.cpu_rdata, D_NIC);
    chk("ld_stall_cycles", 64'(ns), 64'd7);
    tick();
    bus.cpu_en = 1'b0;

    // NUM_TGT=3 instance: good load on idx 1, then decode-error load on idx 3
    bus3.cpu_en = 1'b1; bus3.cpu_wr_en = 1'b0; bus3.cpu_addr = 32'h0000_4000;
    tick(); tick(); tick();
    chk("dec_good_rdata", bus3.cpu_rdata, D_T1);
    tick();
    bus3.cpu_addr = 32'h0000_C000;
    ns = 0;
    #1; ns += int'(bus3.cpu_stall);
    chk("dec_idle_en", 64'(bus3.tgt_en), 64'h0);
    tick(); ns += int'(bus3.cpu_stall);
    chk("dec_err_pulse", 64'(bus3.bus_err), 64'h1);
    chk("dec_err_rdata", bus3.cpu_rdata, 64'h0);
    chk("dec_err_en", 64'(bus3.tgt_en), 64'h0);
    chk("dec_stall_cycles", 64'(ns), 64'd1);
    tick();
    bus3.cpu_en = 1'b0;
    chk("dec_err_once", 64'(bus3.bus_err), 64'h0);

    // Async reset in the RSP state of a dmem load
    bus.cpu_en = 1'b1; bus.cpu_wr_en = 1'b0; bus.cpu_addr = 32'h0000_0000;
    bus.tgt_ready = 4'b1000;
    tick(); tick();
    chk("rr_in_rsp", 64'(dut.state_q), 64'(ST_RSP));
    #1 reset = 1'b1;
    #1;
    chk("rr_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rr_tgt_en", 64'(bus.tgt_en), 64'h0);
    chk("rr_rdata", bus.cpu_rdata, 64'h0);
    #1 reset = 1'b0;

    // Back-to-back loads idx 0 then idx 1 with cpu_en held
    bus.tgt_ready = 4'b1100; bus.tgt_rvalid = 4'b1100;
    bus.tgt_rdata[0 +: 64] = D_A; bus.tgt_rdata[64 +: 64] = D_B;
    tick();
    chk("b2b_req0_en", 64'(bus.tgt_en), 64'b1000);
    tick(); tick();
    chk("b2b_done0_rdata", bus.cpu_rdata, D_A);
    chk("b2b_done0_stall", 64'(bus.cpu_stall), 64'h0);
    tick();
    bus.cpu_addr = 32'h0000_4000;
    #1;
    chk("b2b_idle_stall", 64'(bus.cpu_stall), 64'h1);
    chk("b2b_idle_en", 64'(bus.tgt_en), 64'h0);
    tick();
    chk("b2b_req1_en", 64'(bus.tgt_en), 64'b0100);
    tick(); tick();
    chk("b2b_done1_rdata", bus.cpu_rdata, D_B);
    tick();
    bus.cpu_en = 1'b0;
    tick();
    chk("b2b_no_dup_en", 64'(bus.tgt_en), 64'h0);
    chk("b2b_no_dup_state", 64'(dut.state_q), 64'(ST_IDLE));
    bus.tgt_ready = '0; bus.tgt_rvalid = '0;

`ifdef CMP_MMIO_TIMEOUT_EN
    // Target never ready: timeout after 8 cycles in REQ
    bus.cpu_en = 1'b1; bus.cpu_wr_en = 1'b0; bus.cpu_addr = 32'h0000_0000;
    ns = 0;
    tick();
    repeat (7) begin tick(); ns += int'(bus.bus_err); end
    chk("tmo_no_early_err", 64'(ns), 64'h0);
    chk("tmo_still_stalled", 64'(bus.cpu_stall), 64'h1);
    tick();
    chk("tmo_err", 64'(bus.bus_err), 64'h1);
    chk("tmo_rdata", bus.cpu_rdata, 64'h0);
    chk("tmo_en", 64'(bus.tgt_en), 64'h0);
    chk("tmo_stall", 64'(bus.cpu_stall), 64'h0);
    tick();
    bus.cpu_en = 1'b0;
    chk("tmo_err_once", 64'(bus.bus_err), 64'h0);
`else
    // Target slow to accept: router waits without error
    bus.cpu_en = 1'b1; bus.cpu_wr_en = 1'b0; bus.cpu_addr = 32'h0000_0000;
    tick();
    repeat (20) tick();
    chk("wait_state", 64'(dut.state_q), 64'(ST_REQ));
    chk("wait_no_err", 64'(bus.bus_err), 64'h0);
    chk("wait_stall", 64'(bus.cpu_stall), 64'h1);
    bus.tgt_ready = 4'b1000;
    tick();
    bus.tgt_ready = '0; bus.tgt_rvalid = 4'b1000; bus.tgt_rdata[0 +: 64] = D_NIC;
    tick();
    bus.tgt_rvalid = '0;
    chk("wait_rdata", bus.cpu_rdata, D_NIC);
    tick();
    bus.cpu_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
